sram_port_arbiter: RTL and testbench



---
 rtl/sram_port_arbiter.sv | 137 +++++++++++++
 tb/tb_sram_port_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// ============================================================================
// Module   : sram_port_arbiter
// Brief    : Round-robin arbiter sharing one single-port SRAM between several
//            mem-style requesters, with a built-in array clear sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sram_port_arbiter #(
    parameter int NUM_PORTS      = 2,
    parameter int NUM_WORDS      = 8192,
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = $clog2(NUM_WORDS),
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             clear_i,
    output logic                             clear_busy_o,
    input  logic [NUM_PORTS-1:0]             req_i,
    output logic [NUM_PORTS-1:0]             gnt_o,
    input  logic [NUM_PORTS-1:0]             we_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  addr_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  wdata_i,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] be_i,
    output logic [NUM_PORTS-1:0]             rvalid_o,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]  rdata_o,
    output logic                             sram_req_o,
    output logic                             sram_we_o,
    output logic [ADDR_WIDTH-1:0]            sram_addr_o,
    output logic [DATA_WIDTH-1:0]            sram_wdata_o,
    output logic [DATA_WIDTH/8-1:0]          sram_be_o,
    input  logic [DATA_WIDTH-1:0]            sram_rdata_i
);

    localparam int c_be_width  = DATA_WIDTH / 8;
    localparam int c_ptr_width = $clog2(NUM_PORTS);

    localparam logic [0:0] c_st_clear = 1'b0;
    localparam logic [0:0] c_st_serve = 1'b1;

    localparam logic [ADDR_WIDTH-1:0]  c_last_addr = ADDR_WIDTH'(NUM_WORDS - 1);
    localparam logic [c_ptr_width-1:0] c_ptr_init  = c_ptr_width'(NUM_PORTS - 1);

    logic [0:0]             r_state;
    logic [ADDR_WIDTH-1:0]  r_cnt;
    logic [c_ptr_width-1:0] r_ptr;
    logic                   r_valid;
    logic [c_ptr_width-1:0] r_id;

    logic                   w_any;
    logic                   w_grant;
    logic [c_ptr_width-1:0] w_winner;

    function automatic logic [c_ptr_width-1:0] f_wrap(input logic [c_ptr_width-1:0] p,
                                                      input int k);
        int s;
        s = (int'(p) + k) % NUM_PORTS;
        return c_ptr_width'(s);
    endfunction

    // Scan from lowest priority to highest so the highest-priority requester wins last.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            if (req_i[f_wrap(r_ptr, k)]) begin
                w_any    = 1'b1;
                w_winner = f_wrap(r_ptr, k);
            end
        end
    end

    assign w_grant      = (r_state == c_st_serve) && w_any;
    assign gnt_o        = w_grant ? (NUM_PORTS'(1) << w_winner) : '0;
    assign clear_busy_o = (r_state == c_st_clear);

    always_comb begin
        if (r_state == c_st_clear) begin
            sram_req_o   = 1'b1;
            sram_we_o    = 1'b1;
            sram_addr_o  = r_cnt;
            sram_wdata_o = '0;
            sram_be_o    = '1;
        end else begin
            // With no request the winner index stays 0, so port 0 drives the bus.
            sram_req_o   = w_any;
            sram_we_o    = we_i[w_winner];
            sram_addr_o  = addr_i[int'(w_winner)*ADDR_WIDTH +: ADDR_WIDTH];
            sram_wdata_o = wdata_i[int'(w_winner)*DATA_WIDTH +: DATA_WIDTH];
            sram_be_o    = be_i[int'(w_winner)*c_be_width +: c_be_width];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= (CLEAR_ON_RESET != 0) ? c_st_clear : c_st_serve;
            r_cnt   <= '0;
            r_ptr   <= c_ptr_init;
            r_valid <= 1'b0;
            r_id    <= '0;
        end else begin
            r_valid <= w_grant;
            if (w_grant) begin
                r_id  <= w_winner;
                r_ptr <= w_winner;
            end
            case (r_state)
                c_st_clear: begin
                    if (r_cnt == c_last_addr) begin
                        r_cnt   <= '0;
                        r_state <= c_st_serve;
                    end else begin
                        r_cnt <= r_cnt + ADDR_WIDTH'(1);
                    end
                end
                default: begin
                    if (clear_i) begin
                        r_state <= c_st_clear;
                    end
                end
            endcase
        end
    end

    assign rvalid_o = r_valid ? (NUM_PORTS'(1) << r_id) : '0;

    always_comb begin
        rdata_o = '0;
        if (r_valid) begin
            rdata_o[int'(r_id)*DATA_WIDTH +: DATA_WIDTH] = sram_rdata_i;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
// ============================================================================
// Module   : tb_sram_port_arbiter
// Brief    : Self-checking bench: SRAM model plus arbitration/memory reference.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sram_port_arbiter;

    localparam int NP = 2;
    localparam int NW = 8192;
    localparam int DW = 64;
    localparam int AW = 13;
    localparam int BW = DW / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              clear;
    logic              clear_busy;
    logic [NP-1:0]     req;
    logic [NP-1:0]     gnt;
    logic [NP-1:0]     we;
    logic [NP*AW-1:0]  addr;
    logic [NP*DW-1:0]  wdata;
    logic [NP*BW-1:0]  be;
    logic [NP-1:0]     rvalid;
    logic [NP*DW-1:0]  rdata;
    logic              sram_req;
    logic              sram_we;
    logic [AW-1:0]     sram_addr;
    logic [DW-1:0]     sram_wdata;
    logic [BW-1:0]     sram_be;
    logic [DW-1:0]     sram_rdata = '0;

    always #5 clk = ~clk;

    sram_port_arbiter #(
        .NUM_PORTS(NP), .NUM_WORDS(NW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(1)
    ) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .clear_busy_o(clear_busy),
        .req_i(req), .gnt_o(gnt), .we_i(we), .addr_i(addr), .wdata_i(wdata), .be_i(be),
        .rvalid_o(rvalid), .rdata_o(rdata),
        .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
        .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_rdata_i(sram_rdata)
    );

    // Behavioural single-port SRAM with one cycle of read latency.
    logic [DW-1:0] mem [NW];
    always @(posedge clk) begin
        if (sram_req) begin
            if (sram_we) begin
                for (int b = 0; b < BW; b++)
                    if (sram_be[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    // Reference: expected memory contents, last winner, and the pending response.
    logic [DW-1:0] ref_mem [NW];
    int            last_win;
    bit            exp_rv;
    int            exp_id;
    bit            exp_rd;
    logic [DW-1:0] exp_data;
    int            granted;
    int            checks   = 0;
    int            failures = 0;

    bit            pend  [NP];
    bit            pwe   [NP];
    logic [AW-1:0] paddr [NP];
    logic [DW-1:0] pdata [NP];
    logic [BW-1:0] pbe   [NP];

    task automatic chk(input string tag, input logic [NP*DW-1:0] obs, input logic [NP*DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_port(input int p, input bit r, input bit w, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic [BW-1:0] b);
        req[p]           = r;
        we[p]            = w;
        addr[p*AW +: AW] = a;
        wdata[p*DW +: DW] = d;
        be[p*BW +: BW]   = b;
    endtask

    task automatic idle_all();
        for (int p = 0; p < NP; p++) drive_port(p, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic check_resp(input string tag);
        logic [NP*DW-1:0] m;
        logic [NP*DW-1:0] e;
        m = '0;
        e = '0;
        chk({tag, "/rvalid"}, {{(NP*DW-NP){1'b0}}, rvalid}, exp_rv ? (NP*DW)'(1) << exp_id : '0);
        if (exp_rv) begin
            m[exp_id*DW +: DW] = '1;
            e[exp_id*DW +: DW] = exp_data;
        end
        if (exp_rv && exp_rd) chk({tag, "/rdata"}, rdata, e);
        else                  chk({tag, "/rdata_other"}, rdata & ~m, '0);
    endtask

    // One SERVE cycle: predict the winner, compare, then commit it to the model.
    task automatic cycle_check(input string tag);
        int win;
        int p;
        logic [AW-1:0] a;
        @(negedge clk);
        win = -1;
        for (int k = 1; k <= NP; k++) begin
            p = (last_win + k) % NP;
            if (req[p] && win < 0) win = p;
        end
        chk({tag, "/gnt"}, {{(NP*DW-NP){1'b0}}, gnt}, win >= 0 ? (NP*DW)'(1) << win : '0);
        chk({tag, "/sram_req"}, {{(NP*DW-1){1'b0}}, sram_req}, (NP*DW)'(win >= 0));
        chk({tag, "/busy"}, {{(NP*DW-1){1'b0}}, clear_busy}, '0);
        check_resp(tag);
        if (win >= 0) begin
            a        = addr[win*AW +: AW];
            last_win = win;
            exp_rv   = 1'b1;
            exp_id   = win;
            exp_rd   = !we[win];
            exp_data = ref_mem[a];
            if (we[win])
                for (int b = 0; b < BW; b++)
                    if (be[win*BW + b]) ref_mem[a][b*8 +: 8] = wdata[win*DW + b*8 +: 8];
        end else begin
            exp_rv = 1'b0;
        end
        granted = win;
        @(posedge clk);
        #1;
    endtask

    task automatic run_clear(input string tag, input int ncyc, input bit full);
        int bad;
        bad = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (i == 0) check_resp({tag, "/first"});
            else if (rvalid !== '0) bad++;
            if (!(clear_busy === 1'b1 && gnt === '0 && sram_req === 1'b1 && sram_we === 1'b1 &&
                  sram_addr === AW'(i) && sram_wdata === '0 && sram_be === '1)) bad++;
            @(posedge clk);
            #1;
        end
        exp_rv = 1'b0;
        chk({tag, "/bad_cycles"}, (NP*DW)'(bad), '0);
        if (full) begin
            for (int i = 0; i < NW; i++) ref_mem[i] = '0;
            @(negedge clk);
            chk({tag, "/busy_done"}, {{(NP*DW-1){1'b0}}, clear_busy}, '0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst   = 1'b1;
        clear = 1'b0;
        idle_all();
        for (int i = 0; i < NW; i++) ref_mem[i] = '0;
        req[0] = 1'b1;
        #3;
        chk("reset/busy",   {{(NP*DW-1){1'b0}}, clear_busy}, (NP*DW)'(1));
        chk("reset/gnt",    {{(NP*DW-NP){1'b0}}, gnt}, '0);
        chk("reset/rvalid", {{(NP*DW-NP){1'b0}}, rvalid}, '0);
        chk("reset/rdata",  rdata, '0);
        chk("reset/addr",   {{(NP*DW-AW){1'b0}}, sram_addr}, '0);
        idle_all();
        @(posedge clk);
        #1;
        rst      = 1'b0;
        last_win = NP - 1;
        exp_rv   = 1'b0;
        run_clear("clr_reset", NW, 1'b1);

        // Single port write then read-back.
        drive_port(0, 1'b1, 1'b1, AW'(5), 64'hDEADBEEF_CAFEF00D, 8'hFF);
        cycle_check("p0_wr");
        drive_port(0, 1'b1, 1'b0, AW'(5), '0, '0);
        cycle_check("p0_rd");
        idle_all();
        cycle_check("p0_rsp");

        // Contention: both ports read continuously.
        drive_port(0, 1'b1, 1'b0, AW'(5), '0, '0);
        drive_port(1, 1'b1, 1'b0, AW'(6), '0, '0);
        for (int i = 0; i < 6; i++) cycle_check("contend");
        idle_all();

        // Only port 1 requesting: granted every cycle.
        for (int i = 0; i < 4; i++) begin
            drive_port(1, 1'b1, i[0], AW'(i + 5), 64'h0123_4567_89AB_CDEF + 64'(i), 8'h0F);
            cycle_check("p1_only");
        end
        idle_all();
        cycle_check("p1_flush");

        // Random traffic; losers hold their request until granted.
        for (int p = 0; p < NP; p++) pend[p] = 1'b0;
        for (int c = 0; c < 300; c++) begin
            for (int p = 0; p < NP; p++) begin
                if (!pend[p] && $urandom_range(0, 1) == 1) begin
                    pend[p]  = 1'b1;
                    pwe[p]   = 1'($urandom_range(0, 1));
                    paddr[p] = AW'($urandom_range(0, 15));
                    pdata[p] = {$urandom, $urandom};
                    pbe[p]   = BW'($urandom_range(0, 255));
                end
                drive_port(p, pend[p], pwe[p], paddr[p], pdata[p], pbe[p]);
            end
            cycle_check("rand");
            if (granted >= 0) pend[granted] = 1'b0;
        end
        idle_all();
        cycle_check("rand_flush");

        // Clear requested in the same cycle as a granted read.
        drive_port(0, 1'b1, 1'b1, AW'(3), 64'h1234, 8'hFF);
        cycle_check("mid_wr");
        drive_port(0, 1'b1, 1'b0, AW'(3), '0, '0);
        clear = 1'b1;
        cycle_check("mid_rd");
        clear = 1'b0;
        idle_all();
        run_clear("clr_mid", NW, 1'b1);
        drive_port(0, 1'b1, 1'b0, AW'(3), '0, '0);
        cycle_check("post_clr_rd");
        idle_all();
        cycle_check("post_clr_rsp");

        // Reset asserted part-way through a clear.
        clear = 1'b1;
        cycle_check("clr_pulse");
        clear = 1'b0;
        run_clear("clr_part", 100, 1'b0);
        @(negedge clk);
        chk("part/addr100", {{(NP*DW-AW){1'b0}}, sram_addr}, (NP*DW)'(100));
        rst = 1'b1;
        #1;
        chk("rst_mid/busy",   {{(NP*DW-1){1'b0}}, clear_busy}, (NP*DW)'(1));
        chk("rst_mid/addr",   {{(NP*DW-AW){1'b0}}, sram_addr}, '0);
        chk("rst_mid/rvalid", {{(NP*DW-NP){1'b0}}, rvalid}, '0);
        chk("rst_mid/rdata",  rdata, '0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        last_win = NP - 1;
        exp_rv   = 1'b0;
        run_clear("clr_restart", NW, 1'b1);
        drive_port(0, 1'b1, 1'b0, AW'(3), '0, '0);
        drive_port(1, 1'b1, 1'b0, AW'(5), '0, '0);
        cycle_check("after_rst_a");
        cycle_check("after_rst_b");
        idle_all();
        cycle_check("after_rst_c");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
